// File: rtl/pip_pkg.sv
// Shared constants for the pipeline hazard unit: forwarding mux encodings
// and the default register-address width.
package pip_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int REG_AW_DEF = 5;

endpackage

// File: rtl/pip_fwd_sel.sv
// Per-operand forwarding selector. EX/MEM wins over MEM/WB, and register 0
// is never forwarded because it is hard-wired to zero.
module pip_fwd_sel
  import pip_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwr,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_regwr && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (wb_regwr && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pip_hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use interlock and a
// long-latency writeback scoreboard with a saturating stall-cycle counter.
module pip_hazard_unit
  import pip_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC*REG_AW-1:0]   id_rs,
  input  logic [NSRC-1:0]          id_rs_used,
  input  logic [NSRC*REG_AW-1:0]   ex_rs,
  input  logic [REG_AW-1:0]        ex_rd,
  input  logic                     ex_memrd,
  input  logic [REG_AW-1:0]        mem_rd,
  input  logic                     mem_regwr,
  input  logic [REG_AW-1:0]        wb_rd,
  input  logic                     wb_regwr,
  input  logic                     lng_issue,
  input  logic [REG_AW-1:0]        lng_rd,
  input  logic                     lng_done,
  input  logic [REG_AW-1:0]        lng_done_rd,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic                     stall,
  output logic                     flush_ex,
  output logic [(2**REG_AW)-1:0]   pend,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int NREG = 2 ** REG_AW;

  logic [NREG-1:0]  pend_reg;
  logic [NREG-1:0]  pend_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [NSRC-1:0]  lu_hit;
  logic [NSRC-1:0]  raw_hit;
  logic             load_use;
  logic             waw;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      pip_fwd_sel #(
        .REG_AW(REG_AW)
      ) u_fwd_sel (
        .rs        (ex_rs[gi*REG_AW +: REG_AW]),
        .mem_rd    (mem_rd),
        .mem_regwr (mem_regwr),
        .wb_rd     (wb_rd),
        .wb_regwr  (wb_regwr),
        .sel       (fwd_sel[gi*2 +: 2])
      );

      assign lu_hit[gi]  = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] == ex_rd);
      assign raw_hit[gi] = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] != '0) &&
                           pend_reg[id_rs[gi*REG_AW +: REG_AW]];
    end
  endgenerate

  assign load_use = ex_memrd && (ex_rd != '0) && (|lu_hit);
  assign waw      = lng_issue && (lng_rd != '0) && pend_reg[lng_rd];
  assign stall    = load_use || (|raw_hit) || waw;
  assign flush_ex = stall;

  // Clear is applied before set so a same-cycle re-issue keeps ownership.
  always_comb begin
    pend_next = pend_reg;
    if (lng_done) begin
      pend_next[lng_done_rd] = 1'b0;
    end
    if (lng_issue && !stall && (lng_rd != '0)) begin
      pend_next[lng_rd] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (stall && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign pend      = pend_reg;
  assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_pip_hazard_unit.sv
// Bench for pip_hazard_unit: directed scenarios plus random traffic, all
// compared against a behavioural scoreboard model.
module tb_pip_hazard_unit;

  localparam int AW    = 5;
  localparam int NS    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = 15;
  localparam int NREG  = 32;

  logic            clk;
  logic            rst_n;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0]   id_rs_used;
  logic [NS*AW-1:0] ex_rs;
  logic [AW-1:0]   ex_rd;
  logic            ex_memrd;
  logic [AW-1:0]   mem_rd;
  logic            mem_regwr;
  logic [AW-1:0]   wb_rd;
  logic            wb_regwr;
  logic            lng_issue;
  logic [AW-1:0]   lng_rd;
  logic            lng_done;
  logic [AW-1:0]   lng_done_rd;
  logic [NS*2-1:0] fwd_sel;
  logic            stall;
  logic            flush_ex;
  logic [NREG-1:0] pend;
  logic [CW-1:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  bit m_pend[NREG];
  int m_cnt;

  pip_hazard_unit #(
    .REG_AW(AW),
    .NSRC  (NS),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .ex_rs      (ex_rs),
    .ex_rd      (ex_rd),
    .ex_memrd   (ex_memrd),
    .mem_rd     (mem_rd),
    .mem_regwr  (mem_regwr),
    .wb_rd      (wb_rd),
    .wb_regwr   (wb_regwr),
    .lng_issue  (lng_issue),
    .lng_rd     (lng_rd),
    .lng_done   (lng_done),
    .lng_done_rd(lng_done_rd),
    .fwd_sel    (fwd_sel),
    .stall      (stall),
    .flush_ex   (flush_ex),
    .pend       (pend),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int src(input logic [NS*AW-1:0] v, input int i);
    return int'(v[i*AW +: AW]);
  endfunction

  function automatic logic [1:0] m_fwd(input int r);
    if (mem_regwr && mem_rd != 0 && int'(mem_rd) == r) return 2'd1;
    if (wb_regwr && wb_rd != 0 && int'(wb_rd) == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_stall();
    bit hz;
    hz = 0;
    for (int i = 0; i < NS; i++) begin
      if (ex_memrd && ex_rd != 0 && id_rs_used[i] && src(id_rs, i) == int'(ex_rd)) hz = 1;
      if (id_rs_used[i] && src(id_rs, i) != 0 && m_pend[src(id_rs, i)]) hz = 1;
    end
    if (lng_issue && lng_rd != 0 && m_pend[lng_rd]) hz = 1;
    return hz;
  endfunction

  function automatic logic [NREG-1:0] m_pend_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    m_cnt = 0;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rs_used = '0; ex_rs = '0; ex_rd = '0; ex_memrd = 0;
    mem_rd = '0; mem_regwr = 0; wb_rd = '0; wb_regwr = 0;
    lng_issue = 0; lng_rd = '0; lng_done = 0; lng_done_rd = '0;
  endtask

  // Check everything against the model mid-cycle, then clock and advance the model.
  task automatic cycle(input string tag);
    logic [NS*2-1:0] ef;
    bit st;
    @(negedge clk);
    for (int i = 0; i < NS; i++) ef[i*2 +: 2] = m_fwd(src(ex_rs, i));
    st = m_stall();
    check({tag, ".fwd_sel"}, 64'(fwd_sel), 64'(ef));
    check({tag, ".stall"}, 64'(stall), 64'(st));
    check({tag, ".flush_ex"}, 64'(flush_ex), 64'(st));
    check({tag, ".pend"}, 64'(pend), 64'(m_pend_vec()));
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_cnt));
    $display("%s: fwd=%b stall=%0d pend=%h cnt=%0d", tag, fwd_sel, stall, pend, stall_cnt);
    @(posedge clk);
    if (lng_done) m_pend[lng_done_rd] = 0;
    if (lng_issue && !st && lng_rd != 0) m_pend[lng_rd] = 1;
    if (st && m_cnt < CMAX) m_cnt++;
    #1;
  endtask

  initial begin
    idle_inputs();
    m_reset();
    rst_n = 1'b0;
    #12;
    check("reset.pend", 64'(pend), 64'd0);
    check("reset.stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Forwarding priority and register-0 exclusion.
    mem_regwr = 1; mem_rd = 5; wb_regwr = 1; wb_rd = 5; ex_rs[AW-1:0] = 5;
    cycle("fwd_both");
    check("fwd_both.op0", 64'(fwd_sel[1:0]), 64'd1);
    mem_regwr = 0;
    cycle("fwd_wb");
    mem_regwr = 1; mem_rd = 0; wb_rd = 0; ex_rs[AW-1:0] = 0;
    cycle("fwd_r0");
    idle_inputs();

    // Load-use on operand 1 stalls one cycle, unused operand does not.
    ex_memrd = 1; ex_rd = 8; id_rs[2*AW-1:AW] = 8; id_rs_used = 2'b10;
    cycle("lu_hit");
    check("lu_hit.cnt", 64'(stall_cnt), 64'd1);
    ex_memrd = 0;
    cycle("lu_after");
    ex_memrd = 1; id_rs_used = 2'b00;
    cycle("lu_unused");
    idle_inputs();

    // Long-latency RAW on r3 until completion plus the completion cycle.
    lng_issue = 1; lng_rd = 3;
    cycle("lng_issue3");
    lng_issue = 0; id_rs[AW-1:0] = 3; id_rs_used = 2'b01;
    for (int k = 0; k < 3; k++) cycle("raw3_wait");
    lng_done = 1; lng_done_rd = 3;
    cycle("raw3_done");
    lng_done = 0;
    cycle("raw3_clear");
    check("raw3_clear.stall", 64'(stall), 64'd0);
    idle_inputs();

    // WAW on r4 with a same-cycle completion: issue dropped, then re-issued.
    lng_issue = 1; lng_rd = 4;
    cycle("waw_setup");
    lng_done = 1; lng_done_rd = 4;
    cycle("waw_same");
    lng_done = 0;
    cycle("waw_reissue");
    lng_issue = 0;
    cycle("waw_final");
    check("waw_final.pend4", 64'(pend[4]), 64'd1);
    lng_done = 1; lng_done_rd = 4;
    cycle("waw_drain");
    idle_inputs();

    // Continuous stall to saturation, then async reset mid-stall.
    lng_issue = 1; lng_rd = 9;
    cycle("sat_pend9");
    lng_issue = 0;
    ex_memrd = 1; ex_rd = 8; id_rs[AW-1:0] = 8; id_rs_used = 2'b01;
    for (int k = 0; k < 20; k++) cycle("sat");
    check("sat.cnt", 64'(stall_cnt), 64'(CMAX));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.pend", 64'(pend), 64'd0);
    check("async_rst.cnt", 64'(stall_cnt), 64'd0);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("post_rst");
    idle_inputs();

    // Random traffic over a small register window to force collisions.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NS; i++) begin
        id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
        ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      id_rs_used  = NS'($urandom);
      ex_rd       = AW'($urandom_range(0, 7));
      ex_memrd    = ($urandom_range(0, 3) == 0);
      mem_rd      = AW'($urandom_range(0, 7));
      mem_regwr   = 1'($urandom);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_regwr    = 1'($urandom);
      lng_issue   = ($urandom_range(0, 2) == 0);
      lng_rd      = AW'($urandom_range(0, 7));
      lng_done    = ($urandom_range(0, 2) == 0);
      lng_done_rd = AW'($urandom_range(0, 7));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pip_hazard_unit.md
Name: pip_hazard_unit

Overview:
- Parametrised successor to the 5-stage pipeline forwarding logic. It combines three functions:
  - EX-stage operand forwarding for NSRC source operands.
  - ID-stage load-use interlock.
  - A register scoreboard for long-latency (mul/div) writebacks, with stall generation and a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline registers. It drives the ALU operand muxes, the PC/IF-ID hold and the ID/EX bubble insertion.

Parameters:
- REG_AW, 5, register-address width; the register file holds 2**REG_AW entries and register 0 is hard-wired to zero.
- NSRC, 2, number of source operands per instruction (2 or 3).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  NSRC*REG_AW  ID-stage source register numbers; operand i occupies bits [i*REG_AW +: REG_AW].
- id_rs_used  in  NSRC  per-operand valid bit for id_rs.
- ex_rs  in  NSRC*REG_AW  EX-stage (ID/EX register) source register numbers.
- ex_rd  in  REG_AW  EX-stage destination register.
- ex_memrd  in  1  EX-stage instruction is a load.
- mem_rd  in  REG_AW  EX/MEM destination register.
- mem_regwr  in  1  EX/MEM register-write enable.
- wb_rd  in  REG_AW  MEM/WB destination register.
- wb_regwr  in  1  MEM/WB register-write enable.
- lng_issue  in  1  ID-stage instruction issues to the long-latency unit.
- lng_rd  in  REG_AW  destination register of lng_issue.
- lng_done  in  1  long-latency unit completes this cycle.
- lng_done_rd  in  REG_AW  destination register of lng_done.
- fwd_sel  out  NSRC*2  per-operand ALU mux select: 00 register file, 01 EX/MEM, 10 MEM/WB; 11 is never driven.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_ex  out  1  insert a bubble into ID/EX this cycle; always equal to stall.
- pend  out  2**REG_AW  scoreboard pending bits.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset: pend = 0 and stall_cnt = 0 asynchronously. fwd_sel and stall are combinational and follow their inputs.
- Forwarding (combinational, zero latency), per operand i with r = ex_rs[i]:
  - If mem_regwr and mem_rd != 0 and mem_rd == r, then 01.
  - Else if wb_regwr and wb_rd != 0 and wb_rd == r, then 10.
  - Else 00.
  - EX/MEM has strict priority over MEM/WB when both match. Register 0 is never forwarded.
- Load-use hazard (combinational): ex_memrd and ex_rd != 0 and, for some i, id_rs_used[i] and id_rs[i] == ex_rd.
- Scoreboard RAW hazard: for some i, id_rs_used[i] and id_rs[i] != 0 and pend[id_rs[i]].
- Scoreboard WAW hazard: lng_issue and lng_rd != 0 and pend[lng_rd].
- stall = load-use OR RAW OR WAW. flush_ex = stall.
- Scoreboard update at posedge:
  - lng_done clears pend[lng_done_rd].
  - lng_issue and !stall and lng_rd != 0 sets pend[lng_rd].
  - Set and clear of the same register in the same cycle: set wins. The new issue owns the register.
  - Issue while stalled is ignored; ID re-presents it next cycle.
  - lng_done for a register that is not pending is a no-op.
  - pend[0] is always 0.
- RAW on a register whose lng_done arrives this cycle still stalls this cycle; pend is cleared at the next edge, so the stall lasts exactly one more cycle. The result is then taken from the register file or by MEM/WB forwarding.
- stall_cnt increments by 1 at each posedge where stall = 1 and saturates at 2**CNT_W-1 with no wrap.
- Reset asserted mid-stall clears all pending bits immediately. After release, stall reflects only the current load-use condition.

Decomposition:
- Shared package pip_pkg holds:
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - The default REG_AW.
- One sub-module, pip_fwd_sel: one combinational per-operand priority selector, instantiated NSRC times in a generate loop.
- The scoreboard and the counter stay in the top module.

Test Plan:
- mem_regwr=1, mem_rd=5, wb_regwr=1, wb_rd=5, ex_rs[0]=5 -> fwd_sel[1:0]=01; with mem_regwr=0 -> 10; with mem_rd=wb_rd=0 and ex_rs[0]=0 -> 00.
- ex_memrd=1, ex_rd=8, id_rs[1]=8, id_rs_used=2'b10 -> stall=flush_ex=1 for exactly 1 cycle, stall_cnt 0->1; same stimulus with id_rs_used=2'b00 -> stall=0.
- lng_issue with lng_rd=3, then ID reads r3 -> stall=1 each cycle until lng_done with lng_done_rd=3, plus one further cycle, then stall=0; pend[3] is 1 throughout and 0 afterwards.
- lng_done with lng_done_rd=4 and lng_issue with lng_rd=4 in the same cycle while pend[4]=1 -> WAW stall, issue ignored, pend[4]=0 next cycle; on re-issue pend[4]=1.
- Continuous stall with CNT_W=4 -> stall_cnt reaches 15 and holds; rst_n pulsed low mid-stall -> pend=0 and stall_cnt=0 immediately, without waiting for a clock edge.
